// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory bus: RAM handshake state and bus widths.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned WDOG_W = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // RAM signalled a failed access
    function automatic logic is_ram_error(input ramstate_t s);
        return s == ERROR;
    endfunction

endpackage

// File: rtl/caches_if.sv
// Cache-side request/response handshake plus the single RAM port behind it.
interface caches_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // Caches and RAM model side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Memory controller side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/wait_timer.sv
// Stall watchdog: counts grant cycles without RAM progress and flags expiry.
module wait_timer
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);

    logic [WDOG_W-1:0] r_count;

    // Clear wins over increment; saturate rather than wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WDOG_W'(1);
        end
    end

    assign o_expired = (r_count >= LIMIT);

endmodule

// File: rtl/cache_mem_ctrl.sv
// Arbitrates icache fetches and dcache block accesses onto one RAM port.
// Dcache has priority, a two-word dcache block is never split, and the
// icache is granted after a block's second word if it is waiting.
module cache_mem_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
    input  logic     CLK,
    input  logic     nRST,
    caches_if.slave  cif,
    output logic     mem_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_clr;
    logic   w_inc;
    logic   w_err;
    logic   w_expired;
    logic   w_dreq;
    logic   w_access;
    logic   w_abort;
    logic   r_mem_err;

    assign w_dreq   = cif.dREN | cif.dWEN;
    assign w_access = (cif.ramstate == ACCESS);
    assign w_abort  = w_expired | is_ram_error(cif.ramstate);

    // Watchdog for the current grant
    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (CLK),
        .rst_n     (nRST),
        .i_clr     (w_clr),
        .i_inc     (w_inc),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mem_err <= 1'b0;
        end else if (w_err) begin
            r_mem_err <= 1'b1;
        end
    end

    assign mem_err = r_mem_err;

    // Next state, RAM strobes and cache responses
    always_comb begin
        w_next       = r_state;
        w_clr        = 1'b0;
        w_inc        = 1'b0;
        w_err        = 1'b0;
        cif.iwait    = 1'b1;
        cif.dwait    = 1'b1;
        cif.iload    = '0;
        cif.dload    = '0;
        cif.ramREN   = 1'b0;
        cif.ramWEN   = 1'b0;
        cif.ramaddr  = '0;
        cif.ramstore = '0;

        case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (w_dreq) begin
                    w_next = DGRANT;
                end else if (cif.iREN) begin
                    w_next = IGRANT;
                end
            end

            DGRANT: begin
                if (!w_dreq) begin
                    // Request withdrawn: drop the grant without touching RAM
                    w_next = IDLE;
                end else begin
                    cif.ramaddr  = cif.daddr;
                    cif.ramstore = cif.dstore;
                    cif.ramWEN   = cif.dWEN;
                    cif.ramREN   = cif.dREN & ~cif.dWEN;
                    cif.dload    = cif.ramload;
                    if (w_abort) begin
                        cif.dwait = 1'b0;
                        cif.dload = ERRWORD;
                        w_err     = 1'b1;
                        w_next    = IDLE;
                    end else if (w_access) begin
                        cif.dwait = 1'b0;
                        w_clr     = 1'b1;
                        // Word 0 of a block keeps the grant for word 1
                        if (cif.daddr[2]) begin
                            w_next = cif.iREN ? IGRANT : IDLE;
                        end
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end

            IGRANT: begin
                if (!cif.iREN) begin
                    w_next = IDLE;
                end else begin
                    cif.ramREN  = 1'b1;
                    cif.ramaddr = cif.iaddr;
                    cif.iload   = cif.ramload;
                    if (w_abort) begin
                        cif.iwait = 1'b0;
                        cif.iload = ERRWORD;
                        w_err     = 1'b1;
                        w_next    = IDLE;
                    end else if (w_access) begin
                        cif.iwait = 1'b0;
                        w_clr     = 1'b1;
                        w_next    = w_dreq ? DGRANT : IDLE;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase

        if (w_next != r_state) begin
            w_clr = 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: arbitration, block hold, watchdog, reset.
module tb_cache_mem_ctrl;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    logic mem_err;
    int   n_vec;
    int   n_err;

    caches_if cif ();

    cache_mem_ctrl dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .cif     (cif),
        .mem_err (mem_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        cif.iREN = 1'b0; cif.iaddr = '0;
        cif.dREN = 1'b0; cif.dWEN = 1'b0; cif.daddr = '0; cif.dstore = '0;
        cif.ramload = '0; cif.ramstate = FREE;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        cif.iREN = 1'b1; cif.dWEN = 1'b1; cif.daddr = 32'h100; cif.dstore = 32'h1234;
        cif.ramload = 32'hDEADBEEF; cif.ramstate = ACCESS;
        @(posedge CLK);
        @(negedge CLK);
        n_vec++; if (cif.iwait !== 1'b1) begin n_err++; $display("FAIL rst_iwait: got %b want 1", cif.iwait); end
        n_vec++; if (cif.dwait !== 1'b1) begin n_err++; $display("FAIL rst_dwait: got %b want 1", cif.dwait); end
        n_vec++; if (cif.ramREN !== 1'b0) begin n_err++; $display("FAIL rst_ramREN: got %b want 0", cif.ramREN); end
        n_vec++; if (cif.ramWEN !== 1'b0) begin n_err++; $display("FAIL rst_ramWEN: got %b want 0", cif.ramWEN); end
        n_vec++; if (cif.ramaddr !== 32'h0) begin n_err++; $display("FAIL rst_ramaddr: got %h want 0", cif.ramaddr); end
        n_vec++; if (cif.ramstore !== 32'h0) begin n_err++; $display("FAIL rst_ramstore: got %h want 0", cif.ramstore); end
        n_vec++; if (cif.iload !== 32'h0) begin n_err++; $display("FAIL rst_iload: got %h want 0", cif.iload); end
        n_vec++; if (cif.dload !== 32'h0) begin n_err++; $display("FAIL rst_dload: got %h want 0", cif.dload); end
        n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL rst_mem_err: got %b want 0", mem_err); end
        next_cycle();
        clear_inputs();
        nRST = 1'b1;
        next_cycle();
    endtask

    task automatic test_icache_read();
        cif.iREN = 1'b1; cif.iaddr = 32'h40; cif.ramstate = FREE;
        @(negedge CLK);
        n_vec++; if (cif.ramREN !== 1'b0) begin n_err++; $display("FAIL ird_idle_ramREN: got %b want 0", cif.ramREN); end
        n_vec++; if (cif.iwait !== 1'b1) begin n_err++; $display("FAIL ird_idle_iwait: got %b want 1", cif.iwait); end
        next_cycle();
        cif.ramstate = BUSY;
        @(negedge CLK);
        n_vec++; if (cif.ramREN !== 1'b1) begin n_err++; $display("FAIL ird_g1_ramREN: got %b want 1", cif.ramREN); end
        n_vec++; if (cif.ramaddr !== 32'h40) begin n_err++; $display("FAIL ird_g1_ramaddr: got %h want 40", cif.ramaddr); end
        n_vec++; if (cif.iwait !== 1'b1) begin n_err++; $display("FAIL ird_g1_iwait: got %b want 1", cif.iwait); end
        next_cycle();
        cif.ramstate = ACCESS; cif.ramload = 32'h8C220004;
        @(negedge CLK);
        n_vec++; if (cif.iwait !== 1'b0) begin n_err++; $display("FAIL ird_g2_iwait: got %b want 0", cif.iwait); end
        n_vec++; if (cif.iload !== 32'h8C220004) begin n_err++; $display("FAIL ird_g2_iload: got %h want 8c220004", cif.iload); end
        n_vec++; if (cif.dwait !== 1'b1) begin n_err++; $display("FAIL ird_g2_dwait: got %b want 1", cif.dwait); end
        next_cycle();
        cif.iREN = 1'b0; cif.ramstate = FREE;
        @(negedge CLK);
        n_vec++; if (cif.iwait !== 1'b1) begin n_err++; $display("FAIL ird_done_iwait: got %b want 1", cif.iwait); end
        n_vec++; if (cif.ramREN !== 1'b0) begin n_err++; $display("FAIL ird_done_ramREN: got %b want 0", cif.ramREN); end
        next_cycle();
    endtask

    task automatic test_dblock_write();
        cif.iREN = 1'b1; cif.iaddr = 32'h80;
        cif.dWEN = 1'b1; cif.daddr = 32'h100; cif.dstore = 32'h11111111;
        cif.ramstate = ACCESS; cif.ramload = 32'h33;
        @(negedge CLK);
        n_vec++; if ({cif.ramREN, cif.ramWEN} !== 2'b00) begin n_err++; $display("FAIL dblk_idle_strobes: got %b want 00", {cif.ramREN, cif.ramWEN}); end
        next_cycle();
        @(negedge CLK);
        n_vec++; if ({cif.ramREN, cif.ramWEN} !== 2'b01) begin n_err++; $display("FAIL dblk_w0_strobes: got %b want 01", {cif.ramREN, cif.ramWEN}); end
        n_vec++; if (cif.ramaddr !== 32'h100) begin n_err++; $display("FAIL dblk_w0_ramaddr: got %h want 100", cif.ramaddr); end
        n_vec++; if (cif.ramstore !== 32'h11111111) begin n_err++; $display("FAIL dblk_w0_ramstore: got %h want 11111111", cif.ramstore); end
        n_vec++; if (cif.dwait !== 1'b0) begin n_err++; $display("FAIL dblk_w0_dwait: got %b want 0", cif.dwait); end
        n_vec++; if (cif.iwait !== 1'b1) begin n_err++; $display("FAIL dblk_w0_iwait: got %b want 1", cif.iwait); end
        next_cycle();
        cif.daddr = 32'h104; cif.dstore = 32'h22222222;
        @(negedge CLK);
        n_vec++; if ({cif.ramREN, cif.ramWEN} !== 2'b01) begin n_err++; $display("FAIL dblk_w1_strobes: got %b want 01", {cif.ramREN, cif.ramWEN}); end
        n_vec++; if (cif.ramaddr !== 32'h104) begin n_err++; $display("FAIL dblk_w1_ramaddr: got %h want 104", cif.ramaddr); end
        n_vec++; if (cif.ramstore !== 32'h22222222) begin n_err++; $display("FAIL dblk_w1_ramstore: got %h want 22222222", cif.ramstore); end
        n_vec++; if (cif.dwait !== 1'b0) begin n_err++; $display("FAIL dblk_w1_dwait: got %b want 0", cif.dwait); end
        n_vec++; if (cif.iwait !== 1'b1) begin n_err++; $display("FAIL dblk_w1_iwait: got %b want 1", cif.iwait); end
        next_cycle();
        cif.dWEN = 1'b0;
        @(negedge CLK);
        n_vec++; if ({cif.ramREN, cif.ramWEN} !== 2'b10) begin n_err++; $display("FAIL dblk_ig_strobes: got %b want 10", {cif.ramREN, cif.ramWEN}); end
        n_vec++; if (cif.ramaddr !== 32'h80) begin n_err++; $display("FAIL dblk_ig_ramaddr: got %h want 80", cif.ramaddr); end
        n_vec++; if (cif.iwait !== 1'b0) begin n_err++; $display("FAIL dblk_ig_iwait: got %b want 0", cif.iwait); end
        n_vec++; if (cif.iload !== 32'h33) begin n_err++; $display("FAIL dblk_ig_iload: got %h want 33", cif.iload); end
        n_vec++; if (cif.dwait !== 1'b1) begin n_err++; $display("FAIL dblk_ig_dwait: got %b want 1", cif.dwait); end
        next_cycle();
        clear_inputs();
        @(negedge CLK);
        n_vec++; if ({cif.ramREN, cif.ramWEN, cif.iwait, cif.dwait} !== 4'b0011) begin n_err++; $display("FAIL dblk_end_idle: got %b want 0011", {cif.ramREN, cif.ramWEN, cif.iwait, cif.dwait}); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        cif.dREN = 1'b1; cif.daddr = 32'h200; cif.iREN = 1'b1; cif.iaddr = 32'h44; cif.ramstate = BUSY;
        @(negedge CLK);
        n_vec++; if (cif.ramREN !== 1'b0) begin n_err++; $display("FAIL b2b_idle_ramREN: got %b want 0", cif.ramREN); end
        next_cycle();
        @(negedge CLK);
        n_vec++; if (cif.ramaddr !== 32'h200) begin n_err++; $display("FAIL b2b_d_first_addr: got %h want 200", cif.ramaddr); end
        n_vec++; if ({cif.ramREN, cif.ramWEN} !== 2'b10) begin n_err++; $display("FAIL b2b_d_strobes: got %b want 10", {cif.ramREN, cif.ramWEN}); end
        n_vec++; if ({cif.iwait, cif.dwait} !== 2'b11) begin n_err++; $display("FAIL b2b_d_busy_waits: got %b want 11", {cif.iwait, cif.dwait}); end
        next_cycle();
        cif.ramstate = ACCESS; cif.ramload = 32'hAAAA0000;
        @(negedge CLK);
        n_vec++; if (cif.dwait !== 1'b0) begin n_err++; $display("FAIL b2b_w0_dwait: got %b want 0", cif.dwait); end
        n_vec++; if (cif.dload !== 32'hAAAA0000) begin n_err++; $display("FAIL b2b_w0_dload: got %h want aaaa0000", cif.dload); end
        n_vec++; if (cif.iwait !== 1'b1) begin n_err++; $display("FAIL b2b_w0_iwait: got %b want 1", cif.iwait); end
        next_cycle();
        cif.daddr = 32'h204; cif.ramload = 32'hAAAA0004;
        @(negedge CLK);
        n_vec++; if (cif.ramaddr !== 32'h204) begin n_err++; $display("FAIL b2b_w1_addr: got %h want 204", cif.ramaddr); end
        n_vec++; if (cif.dload !== 32'hAAAA0004) begin n_err++; $display("FAIL b2b_w1_dload: got %h want aaaa0004", cif.dload); end
        next_cycle();
        cif.daddr = 32'h208; cif.ramload = 32'h55;
        @(negedge CLK);
        n_vec++; if (cif.ramaddr !== 32'h44) begin n_err++; $display("FAIL b2b_i_addr: got %h want 44", cif.ramaddr); end
        n_vec++; if (cif.iwait !== 1'b0) begin n_err++; $display("FAIL b2b_i_iwait: got %b want 0", cif.iwait); end
        n_vec++; if (cif.iload !== 32'h55) begin n_err++; $display("FAIL b2b_i_iload: got %h want 55", cif.iload); end
        n_vec++; if (cif.dwait !== 1'b1) begin n_err++; $display("FAIL b2b_i_dwait: got %b want 1", cif.dwait); end
        next_cycle();
        cif.iREN = 1'b0; cif.ramload = 32'h66;
        @(negedge CLK);
        n_vec++; if (cif.ramaddr !== 32'h208) begin n_err++; $display("FAIL b2b_d2_addr: got %h want 208", cif.ramaddr); end
        n_vec++; if (cif.dwait !== 1'b0) begin n_err++; $display("FAIL b2b_d2_dwait: got %b want 0", cif.dwait); end
        next_cycle();
        cif.dREN = 1'b0;
        @(negedge CLK);
        n_vec++; if ({cif.ramREN, cif.ramWEN, cif.dwait} !== 3'b001) begin n_err++; $display("FAIL b2b_drop_nostrobe: got %b want 001", {cif.ramREN, cif.ramWEN, cif.dwait}); end
        next_cycle();
        clear_inputs();
        @(negedge CLK);
        n_vec++; if (cif.ramREN !== 1'b0) begin n_err++; $display("FAIL b2b_end_idle: got %b want 0", cif.ramREN); end
        next_cycle();
    endtask

    task automatic test_error();
        n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL err_pre_mem_err: got %b want 0", mem_err); end
        cif.iREN = 1'b1; cif.iaddr = 32'h60; cif.ramstate = BUSY; cif.ramload = 32'h99;
        next_cycle();
        @(negedge CLK);
        n_vec++; if (cif.iwait !== 1'b1) begin n_err++; $display("FAIL err_busy_iwait: got %b want 1", cif.iwait); end
        next_cycle();
        cif.ramstate = ERROR;
        @(negedge CLK);
        n_vec++; if (cif.iwait !== 1'b0) begin n_err++; $display("FAIL err_iwait: got %b want 0", cif.iwait); end
        n_vec++; if (cif.iload !== 32'hBAD1BAD1) begin n_err++; $display("FAIL err_iload: got %h want bad1bad1", cif.iload); end
        n_vec++; if (cif.dwait !== 1'b1) begin n_err++; $display("FAIL err_dwait: got %b want 1", cif.dwait); end
        next_cycle();
        cif.iaddr = 32'h64; cif.ramstate = ACCESS; cif.ramload = 32'h12345678;
        @(negedge CLK);
        n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL err_mem_err_set: got %b want 1", mem_err); end
        n_vec++; if ({cif.ramREN, cif.iwait} !== 2'b01) begin n_err++; $display("FAIL err_back_idle: got %b want 01", {cif.ramREN, cif.iwait}); end
        next_cycle();
        @(negedge CLK);
        n_vec++; if (cif.ramaddr !== 32'h64) begin n_err++; $display("FAIL err_retry_addr: got %h want 64", cif.ramaddr); end
        n_vec++; if (cif.iwait !== 1'b0) begin n_err++; $display("FAIL err_retry_iwait: got %b want 0", cif.iwait); end
        n_vec++; if (cif.iload !== 32'h12345678) begin n_err++; $display("FAIL err_retry_iload: got %h want 12345678", cif.iload); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        cif.dWEN = 1'b1; cif.daddr = 32'h400; cif.dstore = 32'h77; cif.ramstate = BUSY;
        next_cycle();
        #2;
        n_vec++; if ({cif.ramREN, cif.ramWEN} !== 2'b01) begin n_err++; $display("FAIL rmid_pre_strobes: got %b want 01", {cif.ramREN, cif.ramWEN}); end
        nRST = 1'b0;
        #1;
        n_vec++; if ({cif.ramREN, cif.ramWEN} !== 2'b00) begin n_err++; $display("FAIL rmid_strobes: got %b want 00", {cif.ramREN, cif.ramWEN}); end
        n_vec++; if ({cif.iwait, cif.dwait} !== 2'b11) begin n_err++; $display("FAIL rmid_waits: got %b want 11", {cif.iwait, cif.dwait}); end
        n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL rmid_mem_err: got %b want 0", mem_err); end
        next_cycle();
        nRST = 1'b1;
        cif.dWEN = 1'b0; cif.dREN = 1'b1; cif.daddr = 32'h500; cif.ramstate = ACCESS; cif.ramload = 32'h5A5A;
        @(negedge CLK);
        n_vec++; if ({cif.ramREN, cif.dwait} !== 2'b01) begin n_err++; $display("FAIL rmid_idle: got %b want 01", {cif.ramREN, cif.dwait}); end
        next_cycle();
        @(negedge CLK);
        n_vec++; if (cif.ramaddr !== 32'h500) begin n_err++; $display("FAIL rmid_new_addr: got %h want 500", cif.ramaddr); end
        n_vec++; if (cif.dwait !== 1'b0) begin n_err++; $display("FAIL rmid_new_dwait: got %b want 0", cif.dwait); end
        n_vec++; if (cif.dload !== 32'h5A5A) begin n_err++; $display("FAIL rmid_new_dload: got %h want 5a5a", cif.dload); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_timeout();
        int cyc;
        cyc = 0;
        cif.dREN = 1'b1; cif.daddr = 32'h300; cif.ramstate = BUSY; cif.ramload = 32'h0F0F;
        @(negedge CLK);
        n_vec++; if (cif.ramREN !== 1'b0) begin n_err++; $display("FAIL tmo_idle_ramREN: got %b want 0", cif.ramREN); end
        // Grant cycles 1..255 see BUSY with a running count; the count hits 255 on cycle 256
        for (int k = 1; k <= 400; k++) begin
            @(posedge CLK);
            #1;
            @(negedge CLK);
            if (cif.dwait === 1'b0) begin
                cyc = k;
                break;
            end
        end
        n_vec++; if (cyc != 256) begin n_err++; $display("FAIL tmo_cycle: got %0d want 256", cyc); end
        n_vec++; if (cif.dload !== 32'hBAD1BAD1) begin n_err++; $display("FAIL tmo_dload: got %h want bad1bad1", cif.dload); end
        n_vec++; if (cif.iwait !== 1'b1) begin n_err++; $display("FAIL tmo_iwait: got %b want 1", cif.iwait); end
        n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL tmo_mem_err_pre: got %b want 0", mem_err); end
        next_cycle();
        cif.dREN = 1'b0;
        @(negedge CLK);
        n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL tmo_mem_err: got %b want 1", mem_err); end
        n_vec++; if ({cif.ramREN, cif.dwait} !== 2'b01) begin n_err++; $display("FAIL tmo_idle_after: got %b want 01", {cif.ramREN, cif.dwait}); end
        next_cycle();
        next_cycle();
        @(negedge CLK);
        n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL tmo_mem_err_sticky: got %b want 1", mem_err); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_icache_read();
        test_dblock_write();
        test_back_to_back();
        test_error();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Run-time bound
    initial begin
        #100000;
        $display("FAIL run_bound: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
